heavy_part_bucket_stage: RTL and testbench
==========================================

// Module: heavy_part_bucket_stage
// PURPOSE
//  Parametrised Elastic Sketch heavy-part stage: hashes each key, read-modify-writes one bucket
//  {key, vote+, flag, vote-} in internal dual-port RAM, and emits evicted or rejected flows.
//  Stages chain: value_out feeds the next stage or the light part.
//  Adds generic widths and depth, a configurable eviction ratio, same-bucket RAW forwarding,
//  and automatic RAM clearing at reset or on request.
// PARAMETERS
//  KEY_W      32            key width; keys wider than 32 bits are XOR-folded into 32-bit chunks for the hash
//  CNT_W      32            vote+/vote- width (saturating)
//  IDX_W      12            bucket index width; DEPTH = 2**IDX_W; 1..31
//  LAMBDA     8             eviction ratio: evict when vote- >= LAMBDA*vote+; 1..255
//  HASH_SEED  32'h9E3779B1  multiplicative hash constant
// PORTS
//  clk            in   1            clock
//  reset          in   1            asynchronous, active-high reset
//  key_in_wr      in   1            key valid, one key per cycle
//  key_in         in   KEY_W        flow key
//  key_in_alf     out  1            almost-full to the source; key_in_wr must be 0 while it is high
//  clear_req      in   1            one-cycle pulse: drain the pipeline, then zero all buckets
//  init_done      out  1            high in RUN
//  value_out_wr   out  1            output record valid
//  value_out      out  KEY_W+CNT_W+2   {kind, flag, count[CNT_W], key[KEY_W]}
//  value_out_alf  in   1            downstream almost-full; needs >=4 free entries when it deasserts
// BEHAVIOUR
//  Reset: all pipeline valids = 0, value_out_wr = 0, value_out = 0, init_done = 0, key_in_alf = 1, FSM = INIT, sweep ptr = 0.
//  FSM:
//   INIT: write zero to bucket[ptr] every cycle; ptr++.
//         After ptr = DEPTH-1 is written -> RUN.
//         INIT takes DEPTH cycles. key_in_wr is ignored during INIT.
//   RUN: normal operation. clear_req -> DRAIN.
//   DRAIN: stay until all 3 pipeline valids are 0, then ptr = 0 -> INIT.
//   key_in_alf = (FSM != RUN) | value_out_alf | clear_req, combinational.
//  Hash: f = XOR of the 32-bit chunks of key_in, zero-padded.
//   idx = (f*HASH_SEED mod 2^32)[31:32-IDX_W].
//  Pipeline (one record per key, fixed latency):
//   E0: key sampled; idx registered into S1.
//   S1: RAM read issued (registered-output RAM).
//   S2: bucket data returns; update computed; RAM written at end of S2.
//   E3: value_out_wr = 1 for one cycle, or stays 0 if there is no record.
//  Forwarding: if S2 writes idx X while S1 reads idx X, the next S2 uses the written data, not RAM q.
//   Distance 1 is the only hazard.
//  Update (b = bucket, k = key):
//   empty (vote+ == 0): b = {k, 1, flag 0, vote- 0}; no record.
//   match (b.key == k, vote+ != 0): vote+ += 1, saturating at 2^CNT_W-1; no record.
//   mismatch: v = vote- + 1, saturating.
//     If v >= LAMBDA*vote+ (compare at CNT_W+8 bits): evict.
//       record = {1, b.flag, b.vote+, b.key}; b = {k, 1, flag 1, vote- 0}.
//     Else: b.vote- = v; record = {0, 0, 1, k} (reject to the next stage).
//  kind: 1 = evicted bucket, 0 = rejected incoming key.
//  Each key produces at most one record.
//  Reset mid-operation: in-flight keys are lost, no partial write is committed, and the RAM is re-zeroed.
//  clear_req during INIT or DRAIN is ignored.
// TESTING
//  Reset, IDX_W=4. INIT completes in 16 cycles, then init_done = 1. Key 0xA sent 3x -> no records; bucket = {0xA, 3, 0, 0}.
//  LAMBDA=2, bucket {A, vote+ 1}. Keys B then C hash to the same idx.
//   B -> record {0,0,1,B}, vote- = 1.
//   C -> v = 2 >= 2 -> record {1,0,1,A}; bucket = {C, 1, 1, 0}.
//  Back-to-back same-idx keys A,A,A on an empty bucket -> final vote+ = 3. This proves forwarding; no lost update.
//  CNT_W=4, 20x key A -> vote+ saturates at 15; no wrap.
//  value_out_alf = 1 -> key_in_alf = 1 the same cycle; all 3 in-flight records still emitted.
//  clear_req with 3 keys in flight -> 3 results emitted, DRAIN, INIT 16 cycles, all buckets zero (verified by a key A re-insert with no record).
//  reset asserted mid-INIT at ptr = 7 -> outputs at reset values; INIT restarts from 0.

Source files
------------

// File: rtl/heavy_part_bucket_stage.sv
// Elastic Sketch heavy-part stage: hashed bucket read-modify-write with vote+/vote- eviction.
// Evicted buckets and rejected keys leave on value_out for the next stage or the light part.
module heavy_part_bucket_stage #(
    parameter int          KEY_W     = 32,
    parameter int          CNT_W     = 32,
    parameter int          IDX_W     = 12,
    parameter int          LAMBDA    = 8,
    parameter logic [31:0] HASH_SEED = 32'h9E3779B1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_in_wr,
    input  logic [KEY_W-1:0]        key_in,
    output logic                    key_in_alf,
    input  logic                    clear_req,
    output logic                    init_done,
    output logic                    value_out_wr,
    output logic [KEY_W+CNT_W+1:0]  value_out,
    input  logic                    value_out_alf
);
    localparam int NCH = (KEY_W + 31) / 32;
    localparam int BW  = KEY_W + 2 * CNT_W + 1;
    localparam int OW  = KEY_W + CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [IDX_W-1:0] PTR_LAST = '1;
    localparam logic [7:0]       LAM8     = 8'(LAMBDA);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             init_we, run_accept;

    logic [1:0]       vld_pipe_q, vld_pipe_d;
    logic [KEY_W-1:0] s1_key_q, s1_key_d, s2_key_q, s2_key_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    logic             fwd_vld_q, fwd_vld_d;
    logic [BW-1:0]    fwd_data_q, fwd_data_d;
    logic             value_out_wr_q, value_out_wr_d;
    logic [OW-1:0]    value_out_q, value_out_d;

    logic [NCH*32-1:0] key_pad;
    logic [31:0]       fold, prod;
    logic [IDX_W-1:0]  idx_e0;

    logic [BW-1:0]      mem [2**IDX_W];
    logic [BW-1:0]      ram_q;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_waddr;
    logic [BW-1:0]      ram_wdata;

    logic [BW-1:0]      bucket, upd;
    logic [KEY_W-1:0]   b_key;
    logic [CNT_W-1:0]   b_vp, b_vn, v_inc;
    logic               b_flag;
    logic [CNT_W+7:0]   thr;
    logic               rec_vld;
    logic [OW-1:0]      rec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // Fold wide keys into one 32-bit word, then take the top bits of the multiplicative hash.
    always_comb begin
        key_pad = '0;
        key_pad[KEY_W-1:0] = key_in;
        fold = '0;
        for (int c = 0; c < NCH; c++) fold ^= key_pad[c*32 +: 32];
        prod   = fold * HASH_SEED;
        idx_e0 = IDX_W'(prod >> (32 - IDX_W));
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) state_d = ST_RUN;
            end
            ST_RUN: if (clear_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (vld_pipe_q == 2'b00 && !value_out_wr_q) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        init_we    = (state_q == ST_INIT);
        init_done  = (state_q == ST_RUN);
        run_accept = (state_q == ST_RUN) && key_in_wr;
        key_in_alf = (state_q != ST_RUN) || value_out_alf || clear_req;
    end

    // Bucket update; a write from the previous S2 to the same index overrides the stale RAM read.
    always_comb begin
        bucket = fwd_vld_q ? fwd_data_q : ram_q;
        {b_key, b_vp, b_flag, b_vn} = bucket;
        v_inc   = sat_inc(b_vn);
        thr     = {{CNT_W{1'b0}}, LAM8} * {8'd0, b_vp};
        upd     = bucket;
        rec_vld = 1'b0;
        rec     = '0;
        if (b_vp == CNT_ZERO) begin
            upd = {s2_key_q, CNT_ONE, 1'b0, CNT_ZERO};
        end else if (b_key == s2_key_q) begin
            upd = {b_key, sat_inc(b_vp), b_flag, b_vn};
        end else if ({8'd0, v_inc} >= thr) begin
            rec_vld = 1'b1;
            rec     = {1'b1, b_flag, b_vp, b_key};
            upd     = {s2_key_q, CNT_ONE, 1'b1, CNT_ZERO};
        end else begin
            rec_vld = 1'b1;
            rec     = {2'b00, CNT_ONE, s2_key_q};
            upd     = {b_key, b_vp, b_flag, v_inc};
        end
    end

    always_comb begin
        vld_pipe_d     = {vld_pipe_q[0], run_accept};
        s1_key_d       = key_in;
        s1_idx_d       = idx_e0;
        s2_key_d       = s1_key_q;
        s2_idx_d       = s1_idx_q;
        fwd_vld_d      = vld_pipe_q[1] && vld_pipe_q[0] && (s2_idx_q == s1_idx_q);
        fwd_data_d     = upd;
        value_out_wr_d = vld_pipe_q[1] && rec_vld;
        value_out_d    = value_out_wr_d ? rec : value_out_q;
        ram_we         = init_we || vld_pipe_q[1];
        ram_waddr      = init_we ? ptr_q : s2_idx_q;
        ram_wdata      = init_we ? '0 : upd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q     <= '0;
            s1_key_q       <= '0;
            s1_idx_q       <= '0;
            s2_key_q       <= '0;
            s2_idx_q       <= '0;
            fwd_vld_q      <= 1'b0;
            fwd_data_q     <= '0;
            value_out_wr_q <= 1'b0;
            value_out_q    <= '0;
        end else begin
            vld_pipe_q     <= vld_pipe_d;
            s1_key_q       <= s1_key_d;
            s1_idx_q       <= s1_idx_d;
            s2_key_q       <= s2_key_d;
            s2_idx_q       <= s2_idx_d;
            fwd_vld_q      <= fwd_vld_d;
            fwd_data_q     <= fwd_data_d;
            value_out_wr_q <= value_out_wr_d;
            value_out_q    <= value_out_d;
        end
    end

    // Registered-output RAM; the S2 write is gated by a valid that reset clears immediately.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_q <= mem[s1_idx_q];
    end

    assign value_out_wr = value_out_wr_q;
    assign value_out    = value_out_q;

endmodule

// File: tb/tb_heavy_part_bucket_stage.sv
// Bench for heavy_part_bucket_stage: bucket-array reference model, record scoreboard, directed and random keys.
module tb_heavy_part_bucket_stage;
    localparam int          KW   = 32;
    localparam int          CW   = 4;
    localparam int          IW   = 4;
    localparam int          LAM  = 2;
    localparam logic [31:0] SEED = 32'h9E3779B1;
    localparam int          NB   = 1 << IW;
    localparam int          CMAX = (1 << CW) - 1;

    typedef logic [KW+CW+1:0] rec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_in_wr = 1'b0;
    logic [KW-1:0] key_in = '0;
    logic          key_in_alf;
    logic          clear_req = 1'b0;
    logic          init_done;
    logic          value_out_wr;
    rec_t          value_out;
    logic          value_out_alf = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_key [NB];
    int          m_vp  [NB];
    int          m_flag[NB];
    int          m_vn  [NB];
    rec_t        exp_q [$];

    heavy_part_bucket_stage #(
        .KEY_W(KW), .CNT_W(CW), .IDX_W(IW), .LAMBDA(LAM), .HASH_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .key_in_wr(key_in_wr), .key_in(key_in),
        .key_in_alf(key_in_alf), .clear_req(clear_req), .init_done(init_done),
        .value_out_wr(value_out_wr), .value_out(value_out), .value_out_alf(value_out_alf)
    );

    always #5 clk = ~clk;

    function automatic int hidx(logic [31:0] k);
        logic [63:0] p;
        p = {32'b0, k} * {32'b0, SEED};
        return int'(p[31:0] >> (32 - IW));
    endfunction

    task automatic chk(string nm, longint got, longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_key[i] = '0; m_vp[i] = 0; m_flag[i] = 0; m_vn[i] = 0;
        end
    endtask

    // Sketch rules applied one key at a time in arrival order.
    task automatic model_key(logic [31:0] k);
        int   i, v;
        rec_t r;
        i = hidx(k);
        if (m_vp[i] == 0) begin
            m_key[i] = k; m_vp[i] = 1; m_flag[i] = 0; m_vn[i] = 0;
        end else if (m_key[i] == k) begin
            if (m_vp[i] < CMAX) m_vp[i] = m_vp[i] + 1;
        end else begin
            v = (m_vn[i] < CMAX) ? m_vn[i] + 1 : CMAX;
            if (v >= LAM * m_vp[i]) begin
                r = {1'b1, m_flag[i][0], m_vp[i][CW-1:0], m_key[i]};
                exp_q.push_back(r);
                m_key[i] = k; m_vp[i] = 1; m_flag[i] = 1; m_vn[i] = 0;
            end else begin
                m_vn[i] = v;
                r = {2'b00, CW'(1), k};
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic monitor();
        rec_t e;
        forever begin
            @(negedge clk);
            if (!reset && value_out_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record got %h want none", value_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("record", value_out, e);
                end
            end
        end
    endtask

    task automatic issue(logic [31:0] k);
        int t;
        t = 0;
        while (key_in_alf && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (key_in_alf) begin
            chk("issue_timeout", 1, 0);
            return;
        end
        key_in_wr = 1'b1;
        key_in    = k;
        model_key(k);
        @(negedge clk);
        key_in_wr = 1'b0;
    endtask

    task automatic drain(string nm);
        repeat (8) @(negedge clk);
        chk(nm, exp_q.size(), 0);
    endtask

    // Counts posedges after reset release until init_done; optionally pulses clear_req mid-INIT.
    task automatic wait_init(input bit pulse_clr, output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            clear_req = (pulse_clr && n == 3);
            if (init_done) break;
        end
        clear_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_value_out_wr"}, value_out_wr, 0);
        chk({tag, "_value_out"}, value_out, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_key_in_alf"}, key_in_alf, 1);
    endtask

    logic [31:0] ka, kb, kc, ke, kf;
    logic [31:0] pool [8];
    int          n, t;

    initial begin
        fork monitor(); join_none
        model_clear();
        ka = 32'hA;
        kb = '0; kc = '0; ke = '0; kf = '0;
        for (int k = 1; k < 100000 && (kc == 0 || kf == 0); k++) begin
            if (k != ka && hidx(k) == hidx(ka)) begin
                if (kb == 0) kb = k; else if (kc == 0) kc = k;
            end else if (hidx(k) != hidx(ka)) begin
                if (ke == 0) ke = k; else if (kf == 0 && hidx(k) == hidx(ke)) kf = k;
            end
        end

        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        wait_init(1'b1, n);
        chk("init_cycles", n, NB);
        @(negedge clk);

        // Back-to-back same-bucket hits rely on forwarding; the eviction reveals vote+ = 3.
        issue(ka); issue(ka); issue(ka);
        for (int i = 0; i < 6; i++) issue(kb);
        drain("fwd_drain");

        // Reset during INIT at ptr = 7 restarts the sweep.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_outputs("midinit");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        exp_q.delete();
        wait_init(1'b0, n);
        chk("reinit_cycles", n, NB);
        @(negedge clk);

        // Reject then evict with LAMBDA = 2.
        issue(ka);
        issue(kb);
        issue(kc);
        drain("lambda_drain");

        // Saturation of vote+ at 15; a wrap would make the later mismatches evict.
        for (int i = 0; i < 20; i++) issue(ke);
        for (int i = 0; i < 8; i++) issue(kf);
        drain("sat_drain");

        // Downstream almost-full gates the source immediately; in-flight records still emerge.
        issue(kb); issue(ka); issue(kb);
        value_out_alf = 1'b1;
        #1 chk("alf_passthrough", key_in_alf, 1);
        drain("alf_drain");
        value_out_alf = 1'b0;
        @(negedge clk);

        // clear_req with three keys in flight.
        issue(kc); issue(kb); issue(ka);
        clear_req = 1'b1;
        #1 chk("clear_alf", key_in_alf, 1);
        @(negedge clk);
        clear_req = 1'b0;
        model_clear();
        t = 0;
        while (init_done && t < 50) begin @(negedge clk); t++; end
        chk("clear_leaves_run", init_done, 0);
        t = 0;
        while (!init_done && t < 100) begin @(negedge clk); t++; end
        chk("clear_returns_run", init_done, 1);
        chk("clear_drain", exp_q.size(), 0);
        issue(ka);
        issue(kb);
        drain("post_clear");

        // Random traffic over a small pool to force collisions and hazards.
        pool[0] = ka; pool[1] = kb; pool[2] = kc; pool[3] = ke; pool[4] = kf;
        for (int i = 5; i < 8; i++) pool[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) begin
                value_out_alf = 1'b1;
                repeat ($urandom_range(3, 1)) @(negedge clk);
                value_out_alf = 1'b0;
            end
            issue(pool[$urandom_range(7)]);
            if ($urandom_range(3) == 0) @(negedge clk);
        end
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
